// File: rtl/i_writeback.sv
// ---------------------------------------------------------------------------
// i_writeback -- write-back pipeline stage with a two-deep bypass history.
//
// Purpose:
//   Registers the MEM-stage result (load data or ALU result) for one cycle
//   and hands it to the decode-stage register file. Committed writes also
//   move into a two-entry history (H1 newer, H2 older). Two independent
//   combinational lookup ports search the stage register, then H1, then H2,
//   so decode can bypass values the register file has not yet returned.
//   A saturating counter tracks how many valid instructions were accepted.
//
// Ports:
//   write_clk            in   single clock, all state on its rising edge
//   reset                in   synchronous active-high reset
//   valid_in             in   MEM stage presents an instruction
//   stall                in   hold all state this cycle
//   mem_read_data        in   load result
//   alu_result           in   ALU result
//   write_register_in    in   destination register number
//   mem_to_reg_in        in   1: take mem_read_data, 0: take alu_result
//   reg_write_in         in   instruction writes the register file
//   fwd_reg_a/b          in   bypass lookup register numbers
//   write_data           out  registered write-back value
//   write_register_out   out  registered destination register
//   reg_write_out        out  registered register-file write enable
//   fwd_hit_a/b          out  lookup matched a pending or recent write
//   fwd_data_a/b         out  matched value, 0 on a miss
//   retired_count        out  saturating count of accepted valid instructions
// ---------------------------------------------------------------------------
`ifndef WORD
`define WORD 64
`endif

module i_writeback (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              stall,
  input  logic [`WORD-1:0]  mem_read_data,
  input  logic [`WORD-1:0]  alu_result,
  input  logic [4:0]        write_register_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        fwd_reg_a,
  input  logic [4:0]        fwd_reg_b,
  output logic [`WORD-1:0]  write_data,
  output logic [4:0]        write_register_out,
  output logic              reg_write_out,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [`WORD-1:0]  fwd_data_a,
  output logic [`WORD-1:0]  fwd_data_b,
  output logic [31:0]       retired_count
);

  localparam int unsigned W = `WORD;
  localparam logic [4:0]  XZR = 5'd31;

  // Stage register
  logic [W-1:0] data_q,  data_d;
  logic [4:0]   reg_q,   reg_d;
  logic         we_q,    we_d;

  // Bypass history
  logic         h1_valid_q, h1_valid_d;
  logic [4:0]   h1_reg_q,   h1_reg_d;
  logic [W-1:0] h1_data_q,  h1_data_d;
  logic         h2_valid_q, h2_valid_d;
  logic [4:0]   h2_reg_q,   h2_reg_d;
  logic [W-1:0] h2_data_q,  h2_data_d;

  logic [31:0]  count_q, count_d;

  logic         capture;

  always_comb begin
    capture    = !stall;

    data_d     = data_q;
    reg_d      = reg_q;
    we_d       = we_q;
    h1_valid_d = h1_valid_q;
    h1_reg_d   = h1_reg_q;
    h1_data_d  = h1_data_q;
    h2_valid_d = h2_valid_q;
    h2_reg_d   = h2_reg_q;
    h2_data_d  = h2_data_q;
    count_d    = count_q;

    if (capture) begin
      if (valid_in) begin
        data_d = mem_to_reg_in ? mem_read_data : alu_result;
        reg_d  = write_register_in;
        // Writes to the zero register never commit.
        we_d   = reg_write_in && (write_register_in != XZR);
        if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end else begin
        data_d = '0;
        reg_d  = '0;
        we_d   = 1'b0;
      end

      // Only a write leaving the stage register advances the history, so
      // bubbles and suppressed writes do not push useful entries out.
      if (we_q) begin
        h1_valid_d = 1'b1;
        h1_reg_d   = reg_q;
        h1_data_d  = data_q;
        h2_valid_d = h1_valid_q;
        h2_reg_d   = h1_reg_q;
        h2_data_d  = h1_data_q;
      end
    end
  end

  always_ff @(posedge write_clk) begin
    if (reset) begin
      data_q     <= '0;
      reg_q      <= '0;
      we_q       <= 1'b0;
      h1_valid_q <= 1'b0;
      h1_reg_q   <= '0;
      h1_data_q  <= '0;
      h2_valid_q <= 1'b0;
      h2_reg_q   <= '0;
      h2_data_q  <= '0;
      count_q    <= '0;
    end else begin
      data_q     <= data_d;
      reg_q      <= reg_d;
      we_q       <= we_d;
      h1_valid_q <= h1_valid_d;
      h1_reg_q   <= h1_reg_d;
      h1_data_q  <= h1_data_d;
      h2_valid_q <= h2_valid_d;
      h2_reg_q   <= h2_reg_d;
      h2_data_q  <= h2_data_d;
      count_q    <= count_d;
    end
  end

  assign write_data         = data_q;
  assign write_register_out = reg_q;
  assign reg_write_out      = we_q;
  assign retired_count      = count_q;

  // Lookup ports: identical priority search, instantiated once per port.
  logic [4:0]   lk_reg  [2];
  logic         lk_hit  [2];
  logic [W-1:0] lk_data [2];
  logic         m_stage [2];
  logic         m_h1    [2];
  logic         m_h2    [2];

  assign lk_reg[0] = fwd_reg_a;
  assign lk_reg[1] = fwd_reg_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      // XZR is excluded up front so it can never alias a stored entry.
      assign m_stage[gi] = (lk_reg[gi] != XZR) && we_q       && (reg_q    == lk_reg[gi]);
      assign m_h1[gi]    = (lk_reg[gi] != XZR) && h1_valid_q && (h1_reg_q == lk_reg[gi]);
      assign m_h2[gi]    = (lk_reg[gi] != XZR) && h2_valid_q && (h2_reg_q == lk_reg[gi]);

      assign lk_hit[gi]  = m_stage[gi] || m_h1[gi] || m_h2[gi];
      assign lk_data[gi] = m_stage[gi] ? data_q    :
                           m_h1[gi]    ? h1_data_q :
                           m_h2[gi]    ? h2_data_q : '0;
    end
  endgenerate

  assign fwd_hit_a  = lk_hit[0];
  assign fwd_hit_b  = lk_hit[1];
  assign fwd_data_a = lk_data[0];
  assign fwd_data_b = lk_data[1];

endmodule

// File: tb/tb_i_writeback.sv
// ---------------------------------------------------------------------------
// tb_i_writeback -- directed self-checking bench for i_writeback.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_i_writeback;

  logic        write_clk;
  logic        reset;
  logic        valid_in;
  logic        stall;
  logic [63:0] mem_read_data;
  logic [63:0] alu_result;
  logic [4:0]  write_register_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic [4:0]  fwd_reg_a;
  logic [4:0]  fwd_reg_b;
  logic [63:0] write_data;
  logic [4:0]  write_register_out;
  logic        reg_write_out;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [63:0] fwd_data_a;
  logic [63:0] fwd_data_b;
  logic [31:0] retired_count;

  int checks;
  int errors;

  i_writeback dut (
    .write_clk          (write_clk),
    .reset              (reset),
    .valid_in           (valid_in),
    .stall              (stall),
    .mem_read_data      (mem_read_data),
    .alu_result         (alu_result),
    .write_register_in  (write_register_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .fwd_reg_a          (fwd_reg_a),
    .fwd_reg_b          (fwd_reg_b),
    .write_data         (write_data),
    .write_register_out (write_register_out),
    .reg_write_out      (reg_write_out),
    .fwd_hit_a          (fwd_hit_a),
    .fwd_hit_b          (fwd_hit_b),
    .fwd_data_a         (fwd_data_a),
    .fwd_data_b         (fwd_data_b),
    .retired_count      (retired_count)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic rw,
                       input logic m2r, input logic [63:0] mem, input logic [63:0] alu);
    valid_in          = v;
    write_register_in = r;
    reg_write_in      = rw;
    mem_to_reg_in     = m2r;
    mem_read_data     = mem;
    alu_result        = alu;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 1'b0, 64'h0, 64'h5A5A);
    fwd_reg_a = 5'd6; fwd_reg_b = 5'd0;
    tick(); tick();
    checks++; if (write_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", write_data); end
    checks++; if (write_register_out !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d exp 0", write_register_out); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", reg_write_out); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retired_count); end
    checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 64'h0) begin errors++; $display("FAIL reset_fwd_a got %b/%h exp 0/0", fwd_hit_a, fwd_data_a); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    reset = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 64'hDEAD, 64'h1234);
    tick();
    fwd_reg_a = 5'd5; #1;
    checks++; if (write_data !== 64'h1234) begin errors++; $display("FAIL basic_data got %h exp 1234", write_data); end
    checks++; if (write_register_out !== 5'd5) begin errors++; $display("FAIL basic_reg got %0d exp 5", write_register_out); end
    checks++; if (reg_write_out !== 1'b1) begin errors++; $display("FAIL basic_we got %b exp 1", reg_write_out); end
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", retired_count); end
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h1234) begin errors++; $display("FAIL basic_fwd_stage got %b/%h exp 1/1234", fwd_hit_a, fwd_data_a); end
    $display("test_basic r5=0x1234 done");
  endtask

  task automatic test_xzr();
    drive(1'b1, 5'd31, 1'b1, 1'b1, 64'hAB, 64'h99);
    tick();
    fwd_reg_a = 5'd31; fwd_reg_b = 5'd5; #1;
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL xzr_we got %b exp 0", reg_write_out); end
    checks++; if (write_data !== 64'hAB) begin errors++; $display("FAIL xzr_memdata got %h exp ab", write_data); end
    checks++; if (fwd_hit_a !== 1'b0 || fwd_data_a !== 64'h0) begin errors++; $display("FAIL xzr_fwd got %b/%h exp 0/0", fwd_hit_a, fwd_data_a); end
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h1234) begin errors++; $display("FAIL xzr_h1_r5 got %b/%h exp 1/1234", fwd_hit_b, fwd_data_b); end
    checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL xzr_count got %0d exp 2", retired_count); end
    $display("test_xzr done");
  endtask

  task automatic test_bubble();
    drive(1'b0, 5'd9, 1'b1, 1'b0, 64'h0, 64'h77);
    tick();
    checks++; if (write_data !== 64'h0 || write_register_out !== 5'd0 || reg_write_out !== 1'b0)
      begin errors++; $display("FAIL bubble_stage got %h/%0d/%b exp 0/0/0", write_data, write_register_out, reg_write_out); end
    checks++; if (retired_count !== 32'd2) begin errors++; $display("FAIL bubble_count got %0d exp 2", retired_count); end
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h1234) begin errors++; $display("FAIL bubble_hist_hold got %b/%h exp 1/1234", fwd_hit_b, fwd_data_b); end
    $display("test_bubble done");
  endtask

  task automatic test_history();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 64'h0, 64'h11); tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 64'h0, 64'h22); tick();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 64'h0, 64'h33); tick();
    fwd_reg_a = 5'd3; fwd_reg_b = 5'd4; #1;
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin errors++; $display("FAIL hist_r3_h1 got %b/%h exp 1/22", fwd_hit_a, fwd_data_a); end
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h33) begin errors++; $display("FAIL hist_r4_stage got %b/%h exp 1/33", fwd_hit_b, fwd_data_b); end
    drive(1'b1, 5'd7, 1'b1, 1'b0, 64'h0, 64'h44); tick();
    checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin errors++; $display("FAIL hist_r3_h2 got %b/%h exp 1/22", fwd_hit_a, fwd_data_a); end
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h33) begin errors++; $display("FAIL hist_r4_h1 got %b/%h exp 1/33", fwd_hit_b, fwd_data_b); end
    fwd_reg_b = 5'd5; #1;
    checks++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 64'h0) begin errors++; $display("FAIL hist_r5_evicted got %b/%h exp 0/0", fwd_hit_b, fwd_data_b); end
    fwd_reg_b = 5'd3; #1;
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h22) begin errors++; $display("FAIL hist_same_entry_b got %b/%h exp 1/22", fwd_hit_b, fwd_data_b); end
    checks++; if (retired_count !== 32'd6) begin errors++; $display("FAIL hist_count got %0d exp 6", retired_count); end
    $display("test_history done");
  endtask

  task automatic test_stall();
    fwd_reg_a = 5'd3; fwd_reg_b = 5'd7;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd10 + 5'(i), 1'b1, i[0], 64'h900 + 64'(i), 64'h800 + 64'(i));
      tick();
      checks++; if (write_data !== 64'h44 || write_register_out !== 5'd7 || reg_write_out !== 1'b1)
        begin errors++; $display("FAIL stall_stage_%0d got %h/%0d/%b exp 44/7/1", i, write_data, write_register_out, reg_write_out); end
      checks++; if (retired_count !== 32'd6) begin errors++; $display("FAIL stall_count_%0d got %0d exp 6", i, retired_count); end
      checks++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'h22) begin errors++; $display("FAIL stall_hist_%0d got %b/%h exp 1/22", i, fwd_hit_a, fwd_data_a); end
      $display("test_stall cycle %0d done", i);
    end
    stall = 1'b0;
    drive(1'b1, 5'd12, 1'b1, 1'b1, 64'h5555, 64'h6666);
    tick();
    checks++; if (write_data !== 64'h5555 || write_register_out !== 5'd12) begin errors++; $display("FAIL release_stage got %h/%0d exp 5555/12", write_data, write_register_out); end
    checks++; if (retired_count !== 32'd7) begin errors++; $display("FAIL release_count got %0d exp 7", retired_count); end
    checks++; if (fwd_hit_a !== 1'b0) begin errors++; $display("FAIL release_r3_evicted got %b exp 0", fwd_hit_a); end
    checks++; if (fwd_hit_b !== 1'b1 || fwd_data_b !== 64'h44) begin errors++; $display("FAIL release_r7_h1 got %b/%h exp 1/44", fwd_hit_b, fwd_data_b); end
    $display("test_stall release done");
  endtask

  task automatic test_reset_mid();
    fwd_reg_a = 5'd7; fwd_reg_b = 5'd4;
    reset = 1'b1; stall = 1'b1;
    drive(1'b1, 5'd2, 1'b1, 1'b0, 64'h0, 64'hABCD);
    tick();
    checks++; if (write_data !== 64'h0 || write_register_out !== 5'd0 || reg_write_out !== 1'b0)
      begin errors++; $display("FAIL midreset_stage got %h/%0d/%b exp 0/0/0", write_data, write_register_out, reg_write_out); end
    checks++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin errors++; $display("FAIL midreset_hits got %b/%b exp 0/0", fwd_hit_a, fwd_hit_b); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", retired_count); end
    reset = 1'b0; stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'h0, 64'h0);
    tick();
    checks++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin errors++; $display("FAIL postreset_hits got %b/%b exp 0/0", fwd_hit_a, fwd_hit_b); end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    drive(1'b1, 5'd1, 1'b1, 1'b0, 64'h0, 64'h1);
    tick();
    checks++; if (retired_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach got %h exp ffffffff", retired_count); end
    tick();
    checks++; if (retired_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp ffffffff", retired_count); end
    $display("test_saturate done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; stall = 1'b0;
    fwd_reg_a = 5'd0; fwd_reg_b = 5'd0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'h0, 64'h0);
    test_reset();
    test_basic();
    test_xzr();
    test_bubble();
    test_history();
    test_stall();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
